// File: rtl/line_refill_writer.sv
// Cache line refill writer: packs pairs of upstream beats into RAM words and
// writes one full line starting at the line-aligned base address.
module line_refill_writer #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned BEAT_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned ADDR_WIDTH     = 9
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] LINE_BASE,
  input  logic                  ABORT,
  input  logic                  BEAT_VALID,
  input  logic [BEAT_WIDTH-1:0] BEAT_DATA,
  output logic                  BEAT_READY,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR_W,
  output logic [DATA_WIDTH-1:0] RAM_DATA_IN,
  output logic                  RAM_WR_ENB,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int unsigned BEATS = 2 * WORDS_PER_LINE;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        beat_cnt;
  logic [BEAT_WIDTH-1:0]   hold;
  logic [ADDR_WIDTH-1:0]   base;
  logic                    accept;

  // Status decodes come straight off the state register.
  assign BEAT_READY = (state == S_FILL);
  assign BUSY       = (state != S_IDLE);
  assign DONE       = (state == S_DONE);
  assign accept     = BEAT_VALID & BEAT_READY;

  // State, beat counter, hold register and registered RAM write port.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state       <= S_IDLE;
      beat_cnt    <= '0;
      hold        <= '0;
      base        <= '0;
      RAM_WR_ENB  <= 1'b0;
      RAM_ADDR_W  <= '0;
      RAM_DATA_IN <= '0;
    end else begin
      RAM_WR_ENB <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            state    <= S_FILL;
            base     <= LINE_BASE & LINE_MASK;
            beat_cnt <= '0;
          end
        end
        S_FILL: begin
          // Abort wins over a beat accepted in the same cycle.
          if (ABORT) begin
            state <= S_IDLE;
          end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (!beat_cnt[0]) begin
              hold <= BEAT_DATA;
            end else begin
              RAM_WR_ENB  <= 1'b1;
              RAM_ADDR_W  <= base + ADDR_WIDTH'(beat_cnt >> 1);
              RAM_DATA_IN <= DATA_WIDTH'({BEAT_DATA, hold});
            end
            if (beat_cnt == LAST_BEAT) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_refill_writer.sv
// Self-checking bench for line_refill_writer: directed scenarios plus randomized
// refills compared against a line-level reference model of the expected writes.
module tb_line_refill_writer;

  localparam int WPL = 4;
  localparam int NB  = 2 * WPL;
  localparam int AW  = 9;
  localparam int BW  = 32;
  localparam int DW  = 64;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] line_base;
  logic          abort;
  logic          beat_valid;
  logic [BW-1:0] beat_data;
  logic          beat_ready;
  logic [AW-1:0] ram_addr_w;
  logic [DW-1:0] ram_data_in;
  logic          ram_wr_enb;
  logic          busy;
  logic          done;

  line_refill_writer #(
    .DATA_WIDTH(DW), .BEAT_WIDTH(BW), .WORDS_PER_LINE(WPL), .ADDR_WIDTH(AW)
  ) dut (
    .CLK(clk), .RSTN(rstn), .START(start), .LINE_BASE(line_base), .ABORT(abort),
    .BEAT_VALID(beat_valid), .BEAT_DATA(beat_data), .BEAT_READY(beat_ready),
    .RAM_ADDR_W(ram_addr_w), .RAM_DATA_IN(ram_data_in), .RAM_WR_ENB(ram_wr_enb),
    .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cyc, done_cyc, last_wr_cyc, done_cnt;

  logic [BW-1:0] beats [NB];
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the RAM port and DONE away from the active edge.
  always @(negedge clk) begin
    if (ram_wr_enb === 1'b1) begin
      got_addr.push_back(ram_addr_w);
      got_data.push_back(ram_data_in);
      last_wr_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: a line of WPL words at the aligned base; word k exists only
  // if beat 2k+1 was accepted before any abort.
  function automatic void build_exp(input logic [AW-1:0] base, input int accepted, input bit append);
    int a;
    if (!append) begin
      exp_addr.delete();
      exp_data.delete();
    end
    for (int k = 0; k < WPL; k++) begin
      if (2 * k + 1 < accepted) begin
        a = ((int'(base) / WPL) * WPL + k) % (1 << AW);
        exp_addr.push_back(AW'(a));
        exp_data.push_back({beats[2*k+1], beats[2*k]});
      end
    end
  endfunction

  task automatic clear_mon();
    got_addr.delete();
    got_data.delete();
    done_cnt    = 0;
    done_cyc    = -1;
    last_wr_cyc = -1;
  endtask

  task automatic spec_beats();
    for (int i = 0; i < NB; i++) beats[i] = 32'h11111111 * BW'(i + 1);
  endtask

  // Drives one refill from an idle cycle; gap<0 picks a random 0..3 stall per beat.
  task automatic run_fill(input logic [AW-1:0] base, input int gap, input int abort_at,
                          input bit noise, input bit abort_done);
    int ng;
    start_cyc = cyc;
    start = 1'b1;
    line_base = base;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NB; i++) begin
      beat_valid = 1'b1;
      beat_data  = beats[i];
      abort      = (i == abort_at);
      if (noise) begin
        start     = 1'($urandom);
        line_base = AW'($urandom);
      end
      @(negedge clk);
      beat_valid = 1'b0;
      abort      = 1'b0;
      start      = 1'b0;
      beat_data  = $urandom;
      if (i == abort_at) break;
      if (i < NB - 1) begin
        ng = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        repeat (ng) begin
          if (noise) start = 1'($urandom);
          @(negedge clk);
        end
        start = 1'b0;
      end
    end
    if (abort_done && abort_at < 0) begin
      abort = 1'b1;
      start = noise ? 1'($urandom) : 1'b0;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; line_base = '0; abort = 1'b0;
    beat_valid = 1'b1; beat_data = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    n_tests++; if (beat_ready !== 1'b0) begin n_fail++; $display("FAIL reset beat_ready: got %b want 0", beat_ready); end
    n_tests++; if (ram_wr_enb !== 1'b0) begin n_fail++; $display("FAIL reset ram_wr_enb: got %b want 0", ram_wr_enb); end
    n_tests++; if (ram_addr_w !== '0) begin n_fail++; $display("FAIL reset ram_addr_w: got %h want 0", ram_addr_w); end
    n_tests++; if (ram_data_in !== '0) begin n_fail++; $display("FAIL reset ram_data_in: got %h want 0", ram_data_in); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", done); end
    beat_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stall_free();
    spec_beats();
    build_exp(9'h010, NB, 1'b0);
    clear_mon();
    run_fill(9'h010, 0, -1, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++; if (cyc - start_cyc != 10 || busy !== 1'b0) begin n_fail++; $display("FAIL stall_free busy at cycle %0d: got %b want 0", cyc - start_cyc, busy); end
    n_tests++; if (done_cyc - start_cyc != 9) begin n_fail++; $display("FAIL stall_free done cycle: got %0d want 9", done_cyc - start_cyc); end
    n_tests++; if (last_wr_cyc != done_cyc) begin n_fail++; $display("FAIL stall_free last write cycle: got %0d want %0d", last_wr_cyc, done_cyc); end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL stall_free done pulses: got %0d want 1", done_cnt); end
    n_tests++; if (got_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL stall_free write count: got %0d want %0d", got_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      n_tests++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL stall_free word %0d: got %h=%h want %h=%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_stalled();
    spec_beats();
    build_exp(9'h010, NB, 1'b0);
    clear_mon();
    run_fill(9'h010, 3, -1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL stalled done pulses: got %0d want 1", done_cnt); end
    n_tests++; if (got_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL stalled write count: got %0d want %0d", got_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      n_tests++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL stalled word %0d: got %h=%h want %h=%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_unaligned();
    logic [AW-1:0] bases [3];
    bases[0] = 9'h013; bases[1] = 9'h1FC; bases[2] = 9'h1FF;
    spec_beats();
    for (int b = 0; b < 3; b++) begin
      build_exp(bases[b], NB, 1'b0);
      clear_mon();
      run_fill(bases[b], 0, -1, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      n_tests++; if (got_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL unaligned base %h write count: got %0d want %0d", bases[b], got_addr.size(), exp_addr.size()); end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        n_tests++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
          n_fail++; $display("FAIL unaligned base %h word %0d: got %h=%h want %h=%h", bases[b], i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_abort();
    spec_beats();
    build_exp(9'h010, 3, 1'b0);
    clear_mon();
    run_fill(9'h010, 0, 3, 1'b0, 1'b0);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy after abort: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    n_tests++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort done pulses: got %0d want 0", done_cnt); end
    n_tests++; if (got_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL abort write count: got %0d want %0d", got_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      n_tests++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL abort word %0d: got %h=%h want %h=%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
    build_exp(9'h010, NB, 1'b0);
    clear_mon();
    run_fill(9'h010, 0, -1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    n_tests++; if (done_cnt != 1 || got_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL abort refill after: got %0d done %0d writes want 1 and %0d", done_cnt, got_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      n_tests++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL abort refill after word %0d: got %h=%h want %h=%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    spec_beats();
    build_exp(9'h010, 5, 1'b0);
    clear_mon();
    start = 1'b1; line_base = 9'h010;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      beat_valid = 1'b1; beat_data = beats[i];
      @(negedge clk);
    end
    beat_data = beats[5];
    rstn = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({beat_ready, ram_wr_enb, busy, done, ram_addr_w, ram_data_in} !== '0) begin
      n_fail++; $display("FAIL reset_mid_fill outputs: got rdy=%b we=%b busy=%b done=%b addr=%h data=%h want all 0",
                         beat_ready, ram_wr_enb, busy, done, ram_addr_w, ram_data_in);
    end
    rstn = 1'b1; beat_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (done_cnt != 0 || got_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL reset_mid_fill writes: got %0d writes %0d done want %0d writes 0 done", got_addr.size(), done_cnt, exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      n_tests++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL reset_mid_fill word %0d: got %h=%h want %h=%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
    build_exp(9'h010, NB, 1'b0);
    clear_mon();
    run_fill(9'h010, 0, -1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    n_tests++; if (done_cnt != 1 || got_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL reset_mid_fill refill after: got %0d done %0d writes want 1 and %0d", done_cnt, got_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      n_tests++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL reset_mid_fill refill word %0d: got %h=%h want %h=%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int s1;
    for (int i = 0; i < NB; i++) beats[i] = $urandom;
    build_exp(9'h020, NB, 1'b0);
    build_exp(9'h024, NB, 1'b1);
    clear_mon();
    run_fill(9'h020, 0, -1, 1'b0, 1'b0);
    s1 = start_cyc;
    // START while in DONE must be ignored.
    start = 1'b1; line_base = 9'h100;
    @(negedge clk);
    start = 1'b0;
    run_fill(9'h024, 0, -1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    n_tests++; if (done_cnt != 2) begin n_fail++; $display("FAIL back_to_back done pulses: got %0d want 2", done_cnt); end
    n_tests++; if (done_cyc - s1 != 19) begin n_fail++; $display("FAIL back_to_back second done cycle: got %0d want 19", done_cyc - s1); end
    n_tests++; if (got_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL back_to_back write count: got %0d want %0d", got_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      n_tests++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL back_to_back word %0d: got %h=%h want %h=%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] base;
    int            abort_at;
    for (int it = 0; it < 30; it++) begin
      base = AW'($urandom);
      for (int i = 0; i < NB; i++) beats[i] = $urandom;
      abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
      build_exp(base, (abort_at < 0) ? NB : abort_at, 1'b0);
      clear_mon();
      run_fill(base, -1, abort_at, 1'b1, 1'($urandom));
      repeat (3) @(negedge clk);
      n_tests++; if (done_cnt != ((abort_at < 0) ? 1 : 0)) begin n_fail++; $display("FAIL random %0d done pulses: got %0d abort_at %0d", it, done_cnt, abort_at); end
      n_tests++; if (got_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL random %0d write count: got %0d want %0d", it, got_addr.size(), exp_addr.size()); end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        n_tests++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
          n_fail++; $display("FAIL random %0d word %0d: got %h=%h want %h=%h", it, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stall_free();
    test_stalled();
    test_unaligned();
    test_abort();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
